// File: rtl/hvac_scheduler.sv
// hvac_scheduler: hysteresis-based heat/cool mode sequencer with
// minimum-run / minimum-rest protection and a sticky sensor-fault lockout.
module hvac_scheduler #(
  parameter logic [4:0] HEAT_ON  = 5'd18,
  parameter logic [4:0] HEAT_OFF = 5'd20,
  parameter logic [4:0] COOL_ON  = 5'd22,
  parameter logic [4:0] COOL_OFF = 5'd20,
  parameter int         MIN_RUN  = 8,
  parameter int         MIN_REST = 4,
  parameter int         CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sample_en,
  input  logic [4:0] temperature,
  output logic       heating,
  output logic       cooling,
  output logic [1:0] state,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAT = 2'b01,
    COOL = 2'b10,
    REST = 2'b11
  } state_t;

  // Timer values at which a run may end / a rest ends. Guarded so a zero
  // parameter does not underflow.
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'((MIN_RUN  > 0) ? MIN_RUN  - 1 : 0);
  localparam logic [CNT_W-1:0] REST_LAST = CNT_W'((MIN_REST > 0) ? MIN_REST - 1 : 0);
  localparam logic [CNT_W-1:0] TIMER_MAX = {CNT_W{1'b1}};

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   timer_reg, timer_next;
  logic               fault_reg;
  logic               heating_reg, cooling_reg;
  logic               fault_detect;
  logic               run_done;

  // Next-state and timer logic; a fault seen this cycle already blocks IDLE exits.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    fault_detect = sample_en && ((temperature == 5'd0) || (temperature == 5'd31));
    run_done     = (timer_reg >= RUN_LAST);

    case (state_reg)
      IDLE: begin
        if (enable && sample_en && !fault_reg && !fault_detect) begin
          if (temperature <= HEAT_ON)
            state_next = HEAT;
          else if (temperature >= COOL_ON)
            state_next = COOL;
        end
      end
      HEAT: begin
        if (fault_detect)
          state_next = REST;
        else if (run_done && (!enable || (sample_en && (temperature >= HEAT_OFF))))
          state_next = REST;
      end
      COOL: begin
        if (fault_detect)
          state_next = REST;
        else if (run_done && (!enable || (sample_en && (temperature <= COOL_OFF))))
          state_next = REST;
      end
      REST: begin
        if (timer_reg >= REST_LAST)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state_reg)
      timer_next = '0;
    else if (timer_reg != TIMER_MAX)
      timer_next = timer_reg + 1'b1;
  end

  // State, timer, sticky fault and drive registers; drives lag state by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      fault_reg   <= 1'b0;
      heating_reg <= 1'b0;
      cooling_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      fault_reg   <= fault_reg | fault_detect;
      heating_reg <= (state_reg == HEAT);
      cooling_reg <= (state_reg == COOL);
    end
  end

  assign state   = state_reg;
  assign heating = heating_reg;
  assign cooling = cooling_reg;
  assign fault   = fault_reg;

endmodule

// File: tb/tb_hvac_scheduler.sv
// tb_hvac_scheduler: directed plan plus randomized stimulus, checked by a
// scoreboard fed from a cycle-level behavioural model of the controller.
module tb_hvac_scheduler;

  localparam int MIN_RUN  = 4;
  localparam int MIN_REST = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       sample_en = 1'b0;
  logic [4:0] temperature = 5'd19;
  logic       heating, cooling, fault;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q[$];

  hvac_scheduler #(
    .HEAT_ON(5'd18), .HEAT_OFF(5'd20), .COOL_ON(5'd22), .COOL_OFF(5'd20),
    .MIN_RUN(MIN_RUN), .MIN_REST(MIN_REST), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_en(sample_en),
    .temperature(temperature), .heating(heating), .cooling(cooling),
    .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: mode name, cycles spent in that mode, latched fault.
  // Modes: 0 idle, 1 heat, 2 cool, 3 rest (spec encoding of 'state').
  int m_mode  = 0;
  int m_cycles = 1;
  bit m_fault = 0;
  bit m_heat  = 0;
  bit m_cool  = 0;

  task automatic model_edge(input bit r, input bit en, input bit se, input int t);
    int  nm;
    bit  bad;
    if (r) begin
      m_mode = 0; m_cycles = 1; m_fault = 0; m_heat = 0; m_cool = 0;
      return;
    end
    m_heat = (m_mode == 1);
    m_cool = (m_mode == 2);
    bad = se && (t == 0 || t == 31);
    nm = m_mode;
    if (m_mode == 0) begin
      if (en && se && !m_fault && !bad) begin
        if (t <= 18) nm = 1;
        else if (t >= 22) nm = 2;
      end
    end else if (m_mode == 1 || m_mode == 2) begin
      // A run may end once it has lasted MIN_RUN full cycles.
      if (bad) nm = 3;
      else if (m_cycles >= MIN_RUN &&
               (!en || (se && ((m_mode == 1) ? (t >= 20) : (t <= 20)))))
        nm = 3;
    end else begin
      if (m_cycles >= MIN_REST) nm = 0;
    end
    if (bad) m_fault = 1;
    if (nm != m_mode) m_cycles = 1;
    else m_cycles++;
    m_mode = nm;
  endtask

  // Apply one cycle of inputs and record the expected post-edge response.
  task automatic step(input bit r, input bit en, input bit se, input int t);
    logic [1:0] mm;
    @(negedge clk);
    rst = r; enable = en; sample_en = se; temperature = t[4:0];
    model_edge(r, en, se, t);
    mm = m_mode[1:0];
    exp_q.push_back({mm, m_heat, m_cool, m_fault});
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got=%0d required=%0d", name, got, req);
    end else
      $display("ok   %s: %0d", name, got);
  endtask

  // Monitor: each cycle the DUT presents a result; pop and compare.
  always @(posedge clk) begin
    logic [4:0] got;
    logic [4:0] want;
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = {state, heating, cooling, fault};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got state=%b h=%b c=%b f=%b required state=%b h=%b c=%b f=%b",
                 $time, got[4:3], got[2], got[1], got[0], want[4:3], want[2], want[1], want[0]);
      end else
        $display("txn t=%0t state=%b h=%b c=%b f=%b", $time, got[4:3], got[2], got[1], got[0]);
      checks++;
      if (heating && cooling) begin
        errors++;
        $display("FAIL exclusive t=%0t: got heating=1 cooling=1 required not both", $time);
      end
    end
  end

  initial begin
    int hc;
    int t;
    bit r, en, se;

    // 1: reset then neutral temperature, stays idle
    step(1, 1, 1, 19);
    step(1, 1, 1, 19);
    @(posedge clk); #2;
    chk("reset_state", state, 0);
    chk("reset_heating", heating, 0);
    repeat (10) step(0, 1, 1, 19);

    // 2: heat entry, hysteresis, min run, rest, heating width exactly MIN_RUN
    hc = 0;
    step(0, 1, 1, 17);
    @(posedge clk); #2; hc += heating;
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 1, 20);
      @(posedge clk); #2; hc += heating;
    end
    chk("heat_width", hc, MIN_RUN);
    chk("heat_back_idle", state, 0);

    // 3: cool with hysteresis, then heat request ignored during rest
    step(0, 1, 1, 23);
    repeat (4) step(0, 1, 1, 21);
    step(0, 1, 1, 20);
    repeat (5) step(0, 1, 1, 17);
    repeat (8) step(0, 1, 1, 20);

    // 4: enable dropped early in heat, then disabled idle ignores cold
    step(0, 1, 1, 17);
    step(0, 1, 0, 19);
    repeat (6) step(0, 0, 0, 19);
    repeat (4) step(0, 0, 1, 10);

    // 5: fault during cool forces rest and locks out idle until reset
    step(0, 1, 1, 23);
    step(0, 1, 1, 23);
    step(0, 1, 1, 31);
    @(posedge clk); #2;
    chk("fault_set", fault, 1);
    chk("fault_rest", state, 3);
    repeat (8) step(0, 1, 1, 25);
    chk("fault_locked_idle", state, 0);
    step(1, 1, 1, 25);
    @(posedge clk); #2;
    chk("fault_cleared", fault, 0);

    // 6: reset in the middle of heat drops everything immediately
    step(0, 1, 1, 17);
    step(0, 1, 1, 17);
    step(1, 1, 1, 17);
    @(posedge clk); #2;
    chk("rst_mid_heat_state", state, 0);
    chk("rst_mid_heat_heating", heating, 0);
    repeat (3) step(0, 1, 0, 19);

    // Random phase
    for (int i = 0; i < 1000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      se = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 3)
        t = ($urandom_range(0, 1) == 0) ? 0 : 31;
      else
        t = $urandom_range(12, 28);
      step(r, en, se, t);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
